// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped 8N1/8P1 UART with 16x oversampling, a 16-bit baud
// divider, RX/TX FIFOs, sticky error flags, loopback and a level interrupt.

// Synchronous FIFO used for both the RX and TX queues.
module uart_fifo_buf #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign rdata_o = mem_q[rd_ptr_q];
  // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; stale entries are never visible because count_q gates reads.
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module uart_fifo #(
  parameter logic [7:0] UART_ADDRESS = 8'h00,
  parameter int         FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  logic [15:0] baud_q, presc_q;
  logic [4:0]  cfg_q;
  logic        sync1_q, sync2_q;
  logic        overrun_q, frame_err_q, parity_err_q, irq_q;
  logic [7:0]  dout_q, rdata;
  rx_state_t   rx_state_q;
  logic [3:0]  rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_par_q;
  tx_state_t   tx_state_q;
  logic [3:0]  tx_cnt_q;
  logic [2:0]  tx_bit_q, tx_bit_next;
  logic [7:0]  tx_data_q;
  logic        tx_ser_q;

  // Bus decode.
  logic [7:0] offset;
  logic       in_win, wr_baud, wr_cfg, wr_status, sel_data;
  assign offset    = address - UART_ADDRESS;
  assign in_win    = (address >= UART_ADDRESS) && (offset < 8'd5);
  assign wr_baud   = w_en && in_win && (offset == 8'd0 || offset == 8'd1);
  assign wr_cfg    = w_en && in_win && (offset == 8'd2);
  assign wr_status = w_en && in_win && (offset == 8'd3);
  assign sel_data  = in_win && (offset == 8'd4);

  logic parity_en, parity_odd, rx_irq_en, tx_irq_en, loopback;
  assign {loopback, tx_irq_en, rx_irq_en, parity_odd, parity_en} = cfg_q;

  // FIFOs.
  logic       rx_push, rx_empty, rx_full, tx_pop, tx_empty, tx_full;
  logic [7:0] rx_head, tx_head;

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(r_en && sel_data),
    .wdata_i(rx_shift_q), .rdata_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
  );
  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(w_en && sel_data), .pop_i(tx_pop),
    .wdata_i(din), .rdata_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
  );

  logic tick, rx_line, tx_idle;
  assign tick    = (presc_q == baud_q);
  assign rx_line = sync2_q;
  assign tx_idle = tx_empty && (tx_state_q == TX_IDLE);
  assign tx      = loopback ? 1'b1 : tx_ser_q;
  assign dout    = dout_q;
  assign irq     = irq_q;

  // RX frame completion and error classification at the stop-bit sample.
  logic rx_stop_done, rx_par_bad, frame_set, parity_set, overrun_set;
  assign rx_stop_done = (rx_state_q == RX_STOP) && tick && (rx_cnt_q == 4'd15);
  assign rx_par_bad   = parity_en && (rx_par_q != (^rx_shift_q ^ parity_odd));
  assign rx_push      = rx_stop_done && rx_line && !rx_par_bad;
  assign frame_set    = rx_stop_done && !rx_line;
  assign parity_set   = rx_stop_done && rx_line && rx_par_bad;
  assign overrun_set  = rx_push && rx_full && !(r_en && sel_data);

  // TX pops at a tick from idle, or straight out of the stop bit for gapless back-to-back bytes.
  assign tx_pop = tick && !tx_empty &&
                  ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_cnt_q == 4'd15));
  assign tx_bit_next = tx_bit_q + 3'd1;

  // Programmable registers: divisor and configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q <= '0;
      cfg_q  <= '0;
    end else begin
      if (wr_baud && offset == 8'd0) baud_q[7:0]  <= din;
      if (wr_baud && offset == 8'd1) baud_q[15:8] <= din;
      if (wr_cfg)                    cfg_q        <= din[4:0];
    end
  end

  // Prescaler: restarts on any divisor write and wraps on every tick.
  always_ff @(posedge clk) begin
    if (rst || wr_baud || tick) presc_q <= '0;
    else                        presc_q <= presc_q + 16'd1;
  end

  // Two-flop synchronizer; loopback feeds the serializer straight back in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= loopback ? tx_ser_q : rx;
      sync2_q <= sync1_q;
    end
  end

  // Sticky error flags; a new event on the same cycle as a write-1-to-clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      overrun_q    <= overrun_set | (overrun_q    & ~(wr_status & din[3]));
      frame_err_q  <= frame_set   | (frame_err_q  & ~(wr_status & din[4]));
      parity_err_q <= parity_set  | (parity_err_q & ~(wr_status & din[5]));
    end
  end

  // RX state machine: mid-bit sampling on the 16x tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: if (tick && !rx_line) begin
          rx_state_q <= RX_START;
          rx_cnt_q   <= '0;
        end
        RX_START: if (tick) begin
          if (rx_cnt_q == 4'd7) begin
            rx_state_q <= rx_line ? RX_IDLE : RX_DATA;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
          end else begin
            rx_cnt_q <= rx_cnt_q + 4'd1;
          end
        end
        RX_DATA: if (tick) begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_shift_q <= {rx_line, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= parity_en ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: if (tick) begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_par_q   <= rx_line;
            rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: if (tick) begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) rx_state_q <= rx_line ? RX_IDLE : RX_WAIT_HIGH;
        end
        RX_WAIT_HIGH: if (rx_line) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // TX state machine: each bit held for 16 ticks, serializer output registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      tx_ser_q   <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (tx_pop) begin
          tx_data_q  <= tx_head;
          tx_ser_q   <= 1'b0;
          tx_cnt_q   <= '0;
          tx_state_q <= TX_START;
        end
        TX_START: if (tick) begin
          tx_cnt_q <= tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_ser_q   <= tx_data_q[0];
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: if (tick) begin
          tx_cnt_q <= tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            if (tx_bit_q != 3'd7) begin
              tx_bit_q <= tx_bit_next;
              tx_ser_q <= tx_data_q[tx_bit_next];
            end else if (parity_en) begin
              tx_ser_q   <= ^tx_data_q ^ parity_odd;
              tx_state_q <= TX_PARITY;
            end else begin
              tx_ser_q   <= 1'b1;
              tx_state_q <= TX_STOP;
            end
          end
        end
        TX_PARITY: if (tick) begin
          tx_cnt_q <= tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_ser_q   <= 1'b1;
            tx_state_q <= TX_STOP;
          end
        end
        TX_STOP: if (tick) begin
          tx_cnt_q <= tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            if (tx_pop) begin
              tx_data_q  <= tx_head;
              tx_ser_q   <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Read-data mux; unmapped offsets and an empty RX FIFO read as zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves rdata unassigned (no latch).
    rdata = 8'h00;
    if (in_win) begin
      case (offset)
        8'd0:    rdata = baud_q[7:0];
        8'd1:    rdata = baud_q[15:8];
        8'd2:    rdata = {3'b000, cfg_q};
        8'd3:    rdata = {2'b00, parity_err_q, frame_err_q, overrun_q, tx_idle, !tx_full, !rx_empty};
        8'd4:    rdata = rx_empty ? 8'h00 : rx_head;
        default: rdata = 8'h00;
      endcase
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (r_en) dout_q <= rdata;
      irq_q <= (rx_irq_en && !rx_empty) || (tx_irq_en && tx_idle);
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: a register-access vector table followed by
// hand-written serial sequences. Two instances (depth 8 and depth 4) share
// all inputs; each check picks the instance it is about.
module tb_uart_fifo;
  localparam logic [7:0] A_BLO = 8'h00, A_BHI = 8'h01, A_CFG = 8'h02,
                         A_STS = 8'h03, A_DAT = 8'h04;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0, address = '0;
  logic       w_en = 1'b0, r_en = 1'b0, rx = 1'b1;
  logic [7:0] dout8, dout4;
  logic       tx8, tx4, irq8, irq4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_fifo #(.UART_ADDRESS(8'h00), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout8), .rx(rx), .tx(tx8), .irq(irq8)
  );
  uart_fifo #(.UART_ADDRESS(8'h00), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout4), .rx(rx), .tx(tx4), .irq(irq4)
  );

  logic mon_en = 1'b0, tx_low_seen = 1'b0;
  always @(negedge clk) if (mon_en && tx8 !== 1'b1) tx_low_seen = 1'b1;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%02h exp=0x%02h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; din = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d8, output logic [7:0] d4);
    @(negedge clk);
    address = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    d8 = dout8;
    d4 = dout4;
  endtask

  // Drives one frame on rx at divisor 0 (16 clocks per bit).
  task automatic send_frame(input logic [7:0] b, input logic use_par, input logic par_bit,
                            input logic stop_bit);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    if (use_par) begin
      rx = par_bit;
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r8, r4, b;
    int w;

    vecs[0]  = '{1'b0, A_STS, 8'h00, 8'h06};
    vecs[1]  = '{1'b0, A_BLO, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, A_BLO, 8'h34, 8'h00};
    vecs[3]  = '{1'b0, A_BLO, 8'h00, 8'h34};
    vecs[4]  = '{1'b1, A_BHI, 8'h12, 8'h00};
    vecs[5]  = '{1'b0, A_BHI, 8'h00, 8'h12};
    vecs[6]  = '{1'b1, A_CFG, 8'hFF, 8'h00};
    vecs[7]  = '{1'b0, A_CFG, 8'h00, 8'h1F};
    vecs[8]  = '{1'b1, A_CFG, 8'h00, 8'h00};
    vecs[9]  = '{1'b0, 8'h05, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[11] = '{1'b0, A_DAT, 8'h00, 8'h00};
    vecs[12] = '{1'b1, A_STS, 8'hFF, 8'h00};
    vecs[13] = '{1'b0, A_STS, 8'h00, 8'h06};
    vecs[14] = '{1'b1, A_BHI, 8'h00, 8'h00};
    vecs[15] = '{1'b1, A_BLO, 8'h00, 8'h00};

    // Reset state of the pins.
    do_reset();
    check("rst_tx", {7'b0, tx8}, 8'h01);
    check("rst_irq", {7'b0, irq8}, 8'h00);
    check("rst_dout", dout8, 8'h00);

    // Register access table.
    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, r8, r4);
        check($sformatf("vec%0d", i), r8, vecs[i].exp);
      end
    end

    // Basic TX of 0x55 at divisor 0.
    do_reset();
    b = 8'h55;
    bus_write(A_DAT, b);
    w = 0;
    while (tx8 !== 1'b0 && w < 3) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_seen", {7'b0, tx8}, 8'h00);
    repeat (15) @(negedge clk);
    check("tx_start_end", {7'b0, tx8}, 8'h00);
    @(negedge clk);
    check("tx_bit0_begin", {7'b0, tx8}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge clk);
      check($sformatf("tx_bit%0d", i), {7'b0, tx8}, {7'b0, b[i]});
      repeat (8) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("tx_stop", {7'b0, tx8}, 8'h01);
    bus_read(A_STS, r8, r4);
    check("tx_busy_status", r8, 8'h02);
    repeat (6) @(negedge clk);
    bus_read(A_STS, r8, r4);
    check("tx_idle_status", r8, 8'h06);

    // Loopback with odd parity.
    do_reset();
    bus_write(A_CFG, 8'h13);
    mon_en = 1'b1;
    bus_write(A_DAT, 8'hA3);
    bus_write(A_DAT, 8'h00);
    bus_write(A_DAT, 8'hFF);
    repeat (600) @(negedge clk);
    mon_en = 1'b0;
    check("lb_tx_pin_high", {7'b0, tx_low_seen}, 8'h00);
    bus_read(A_STS, r8, r4);
    check("lb_status", r8, 8'h07);
    bus_read(A_DAT, r8, r4);
    check("lb_rd0", r8, 8'hA3);
    bus_read(A_DAT, r8, r4);
    check("lb_rd1", r8, 8'h00);
    bus_read(A_DAT, r8, r4);
    check("lb_rd2", r8, 8'hFF);
    bus_read(A_STS, r8, r4);
    check("lb_status_after", r8, 8'h06);

    // RX overrun: depth-4 instance overflows on the 5th frame, depth-8 does not.
    do_reset();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
    bus_read(A_STS, r8, r4);
    check("ovr_status8", r8, 8'h07);
    check("ovr_status4", r4, 8'h0F);
    for (int i = 0; i < 6; i++) begin
      bus_read(A_DAT, r8, r4);
      check($sformatf("ovr8_rd%0d", i), r8, (i < 5) ? 8'(i + 1) : 8'h00);
      check($sformatf("ovr4_rd%0d", i), r4, (i < 4) ? 8'(i + 1) : 8'h00);
    end
    bus_write(A_STS, 8'h08);
    bus_read(A_STS, r8, r4);
    check("ovr_cleared4", r4, 8'h06);

    // RX errors: bad stop, bad parity, start glitch.
    do_reset();
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    bus_read(A_STS, r8, r4);
    check("frame_err", r8, 8'h16);
    bus_write(A_STS, 8'h10);
    bus_read(A_STS, r8, r4);
    check("frame_err_clr", r8, 8'h06);
    bus_write(A_CFG, 8'h01);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    bus_read(A_STS, r8, r4);
    check("parity_err", r8, 8'h26);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    bus_read(A_STS, r8, r4);
    check("parity_ok_status", r8, 8'h27);
    bus_read(A_DAT, r8, r4);
    check("parity_ok_data", r8, 8'h07);
    bus_write(A_STS, 8'h38);
    bus_write(A_CFG, 8'h00);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(A_STS, r8, r4);
    check("glitch_status", r8, 8'h06);

    // TX FIFO full, dropped 9th write, and push+pop on the same cycle while full.
    do_reset();
    bus_write(A_CFG, 8'h10);
    bus_write(A_BLO, 8'hFF);
    address = A_DAT; din = 8'h10; w_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      din = 8'(8'h10 + i);
    end
    @(negedge clk);
    w_en = 1'b0;
    bus_read(A_STS, r8, r4);
    check("txf_full", r8, 8'h00);
    repeat (244) @(negedge clk);
    address = A_DAT; din = 8'h19; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
    bus_read(A_STS, r8, r4);
    check("txf_full_after_pushpop", r8, 8'h00);
    bus_write(A_BLO, 8'h00);
    repeat (200) @(negedge clk);
    bus_read(A_DAT, r8, r4);
    check("txf_rd0", r8, 8'h10);
    repeat (1300) @(negedge clk);
    bus_read(A_STS, r8, r4);
    check("txf_status_done", r8, 8'h07);
    for (int i = 0; i < 9; i++) begin
      bus_read(A_DAT, r8, r4);
      check($sformatf("txf_rd%0d", i + 1), r8,
            (i < 7) ? 8'(8'h11 + i) : ((i == 7) ? 8'h19 : 8'h00));
    end

    // Interrupt behaviour.
    do_reset();
    bus_write(A_CFG, 8'h04);
    @(negedge clk);
    check("irq_rx_empty", {7'b0, irq8}, 8'h00);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("irq_rx_set", {7'b0, irq8}, 8'h01);
    bus_read(A_DAT, r8, r4);
    check("irq_rx_data", r8, 8'h5A);
    @(negedge clk);
    check("irq_rx_clear", {7'b0, irq8}, 8'h00);
    bus_write(A_CFG, 8'h08);
    @(negedge clk);
    check("irq_tx_idle", {7'b0, irq8}, 8'h01);

    // Reset in the middle of a TX frame.
    bus_write(A_CFG, 8'h0C);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    bus_write(A_DAT, 8'h00);
    repeat (40) @(negedge clk);
    check("mid_tx_low", {7'b0, tx8}, 8'h00);
    check("mid_irq_high", {7'b0, irq8}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", {7'b0, tx8}, 8'h01);
    check("rst_mid_irq", {7'b0, irq8}, 8'h00);
    rst = 1'b0;
    bus_read(A_STS, r8, r4);
    check("rst_mid_status", r8, 8'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised memory-mapped UART with 16-bit baud divider, configurable-depth RX and TX FIFOs, optional parity, sticky error flags, loopback and a level interrupt. It sits on the SoC I/O bus as the next-generation serial peripheral: 8 data bits, 1 stop bit, 16x oversampling, LSB first.

## Interface
- UART_ADDRESS, 8'h00, base of the 5-register window
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..64
- clk  input  1  system clock
- rst  input  1  reset; one clock, synchronous and active-high
- din  input  8  bus write data
- address  input  8  bus address
- w_en  input  1  write strobe, one cycle per access
- r_en  input  1  read strobe, one cycle per access
- dout  output  8  registered read data
- rx  input  1  serial input, asynchronous
- tx  output  1  serial output, idle high
- irq  output  1  level interrupt

## Operation
- Register map, offsets from UART_ADDRESS:
  - +0 BAUD_LO (R/W)
  - +1 BAUD_HI (R/W)
  - +2 CONFIG (R/W): b0 parity_en, b1 parity_odd, b2 rx_irq_en, b3 tx_irq_en, b4 loopback; b7:5 read 0.
  - +3 STATUS: b0 rx_avail, b1 tx_not_full, b2 tx_idle (TX FIFO empty and shifter idle), b3 overrun, b4 frame_err, b5 parity_err. Writing 1 clears b3-b5; other bits are read-only.
  - +4 DATA: a write pushes the TX FIFO; a read pops the RX FIFO.
- Reads of any other address return 0.
- Tick generator: a 16-bit prescaler counts to {BAUD_HI,BAUD_LO}, then wraps to 0 and pulses tick for 1 cycle. Tick period = divisor+1 clocks; one bit = 16 ticks. A write to BAUD_LO or BAUD_HI clears the prescaler.
- RX path:
  - rx passes through a 2-flop synchronizer clocked every cycle. In loopback the synchronizer input is the internal tx serializer output, and the tx pin is held 1.
  - IDLE: on a tick with the synced line at 0, go to START.
  - START: after 8 ticks, if the line is 0 go to DATA; otherwise it was a false start, go to IDLE.
  - DATA: sample every 16 ticks, 8 bits, shift LSB first, then go to PARITY if parity_en, else STOP.
  - PARITY: sample after 16 ticks; compare to even/odd parity of the data (parity_odd=1 means odd).
  - STOP: sample after 16 ticks.
    - Stop=0: set frame_err, discard the byte, go to WAIT_HIGH, which returns to IDLE when the line is 1.
    - Parity mismatch: set parity_err, discard the byte.
    - Otherwise push the byte to the RX FIFO; if the FIFO is full, drop the byte and set overrun.
    - Return to IDLE.
- TX path:
  - IDLE: on a tick with the TX FIFO non-empty, pop the head, drive tx=0 (start bit).
  - Then each bit lasts 16 ticks: 8 data bits LSB first, the parity bit if parity_en, then stop=1.
  - After the stop bit, go to IDLE; back-to-back bytes have no extra gap.
- CONFIG writes take effect immediately, including mid-frame. Software avoids changing parity mid-frame; no protection is provided.
- Writing DATA while the TX FIFO is full drops the byte. No flag is set; software polls tx_not_full.
- Reading DATA while the RX FIFO is empty returns 0 and does not pop.
- FIFO: a simultaneous push and pop on the same cycle is legal at any occupancy. When full, the pop completes and the push succeeds. Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- irq = (rx_irq_en & rx_avail) | (tx_irq_en & tx_idle), registered.

## Timing
- Reset values:
  - dout=0, tx=1, irq=0
  - divisor=0, CONFIG=0, STATUS flags 0
  - both FIFOs empty, both FSMs IDLE, prescaler 0, synchronizer flops 1
  - Reset mid-frame aborts both FSMs immediately; tx returns to 1 the next cycle.
- Read latency: dout is valid on the clock after r_en and holds until the next access. A DATA read presents the pre-pop head; the pop is visible in STATUS one cycle later.
- Write latency: a register is updated on the edge where w_en is sampled. After a DATA write, tx_not_full/tx_idle reflect the push on the next cycle.
- RX byte to rx_avail=1: 1 cycle after the stop-bit sample tick. irq follows 1 cycle later.
- With divisor=0, tick is every clock:
  - A frame is 160 clocks, or 176 with parity.
  - The TX start bit begins at most 2 clocks after the DATA write, from idle.
- A W1C write on the same cycle as a new error event leaves the flag set (set wins).

## Test plan
- **Basic TX:** divisor=0, write DATA=0x55 → tx: start 0 for 16 clocks, then 1,0,1,0,1,0,1,0 at 16 clocks each, stop 1; tx_idle=1 after 160 clocks.
- **Loopback with parity:** loopback=1, parity_en=1, parity_odd=1, write 0xA3,0x00,0xFF → RX FIFO returns 0xA3,0x00,0xFF in order, no error flags, tx pin stays 1 throughout.
- **RX overrun:** FIFO_DEPTH=4, drive 5 frames on rx (0x01..0x05) without reading → reads return 0x01..0x04; overrun=1; a 6th read returns 0. Write STATUS=0x08 → overrun=0.
- **RX errors:**
  - A frame with stop=0 → frame_err=1, FIFO unchanged.
  - With parity_en, a frame with a wrong parity bit → parity_err=1, byte discarded.
  - A 4-clock low glitch at divisor=0 → false start, no flags set.
- **TX FIFO full and simultaneous access:** FIFO_DEPTH=8, write 9 bytes in consecutive cycles → 8 are transmitted. Also pop and push on the same cycle with the FIFO full → count stays 8, no byte lost.
- **Interrupt and reset:**
  - rx_irq_en=1: receiving a byte → irq=1; reading DATA → irq=0 within 2 cycles.
  - Asserting rst mid-TX-frame → tx=1, STATUS=0x06, irq=0 the next cycle.
